// File: rtl/drlp_wr_buffer_if.sv
// drlp_wr_buffer_if: PE-result item stream plus DMA write port of the
// write-side packer. With DRLP_WR_BUF_CNT_EN defined, the bundle also carries
// the per-session written-word count.
interface drlp_wr_buffer_if #(
  parameter int INPUT_WIDTH    = 48,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int DMA_ADDR_WIDTH = 32
);
  // session control
  logic                      wr_dma;
  logic [DMA_ADDR_WIDTH-1:0] dma_base_addr;
  // item stream
  logic [1:0]                mode;
  logic [INPUT_WIDTH-1:0]    data;
  logic                      valid;
  logic                      last;
  logic                      ready;
  // DMA write port
  logic                      dma_ready;
  logic                      dma_wr_en;
  logic [DMA_ADDR_WIDTH-1:0] dma_wr_addr;
  logic [OUTPUT_WIDTH-1:0]   dma_wr_data;
  logic                      done;
`ifdef DRLP_WR_BUF_CNT_EN
  logic [15:0]               wr_count;

  modport master (
    output wr_dma, dma_base_addr, mode, data, valid, last, dma_ready,
    input  ready, dma_wr_en, dma_wr_addr, dma_wr_data, done, wr_count
  );

  modport slave (
    input  wr_dma, dma_base_addr, mode, data, valid, last, dma_ready,
    output ready, dma_wr_en, dma_wr_addr, dma_wr_data, done, wr_count
  );
`else
  modport master (
    output wr_dma, dma_base_addr, mode, data, valid, last, dma_ready,
    input  ready, dma_wr_en, dma_wr_addr, dma_wr_data, done
  );

  modport slave (
    input  wr_dma, dma_base_addr, mode, data, valid, last, dma_ready,
    output ready, dma_wr_en, dma_wr_addr, dma_wr_data, done
  );
`endif
endinterface

// File: rtl/drlp_wr_buffer.sv
// drlp_wr_buffer: write-side DMA packer. Result items of 32/40/48 valid bits
// (selected per item by mode) are packed LSB-first into 32-bit words written
// to consecutive word addresses starting at the session base address. The
// final item of a packet flushes a zero-padded tail word, then done pulses.
// Optional feature macro: DRLP_WR_BUF_CNT_EN adds a saturating 16-bit count
// of words written in the current session.
module drlp_wr_buffer #(
  parameter int INPUT_WIDTH    = 48,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int DMA_ADDR_WIDTH = 32
) (
  input logic             i_clk,
  input logic             i_rst,
  drlp_wr_buffer_if.slave bus
);

  // Accumulator holds at most one partial word (<32 bits) plus one item.
  localparam int ACC_W = OUTPUT_WIDTH + INPUT_WIDTH;
  localparam int CNT_W = $clog2(ACC_W);
  localparam logic [CNT_W-1:0] OW_C  = CNT_W'(OUTPUT_WIDTH);
  localparam logic [CNT_W-1:0] W32_C = CNT_W'(32);
  localparam logic [CNT_W-1:0] W40_C = CNT_W'(40);
  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(INPUT_WIDTH);

  typedef enum logic [0:0] {
    S_FILL,   // accepting items
    S_FLUSH   // last item taken, draining the remaining bits
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0]          acc, acc_sh, acc_nxt, item_ext;
  logic [CNT_W-1:0]          cnt, cnt_sh, cnt_nxt, item_w;
  logic [INPUT_WIDTH-1:0]    item_mask;
  logic [DMA_ADDR_WIDTH-1:0] next_addr;
  logic                      flush, emit, ready, accept, done_set;

  logic                      wr_en_q;
  logic [DMA_ADDR_WIDTH-1:0] wr_addr_q;
  logic [OUTPUT_WIDTH-1:0]   wr_data_q;
  logic                      done_q;

  assign flush = (state == S_FLUSH);

  // A word leaves when a full one is buffered, or when draining a tail.
  assign emit = bus.wr_dma & bus.dma_ready &
                ((cnt >= OW_C) | (flush & (cnt != '0)));

  // Post-emit view of the accumulator; new items land on top of this, which
  // lets an accept and an emit share an edge.
  always_comb begin
    acc_sh = acc;
    cnt_sh = cnt;
    if (emit) begin
      acc_sh = acc >> OUTPUT_WIDTH;
      cnt_sh = (cnt >= OW_C) ? (cnt - OW_C) : '0;
    end
  end

  // Room for another item only while less than a full word stays behind.
  assign ready  = bus.wr_dma & ~flush & (cnt_sh < OW_C);
  assign accept = bus.valid & ready;

  // Item width by mode; bits above the width are ignored.
  always_comb begin
    item_w = WIN_C;
    case (bus.mode)
      2'b01:   item_w = W32_C;
      2'b10:   item_w = W40_C;
      default: item_w = WIN_C;
    endcase
  end

  assign item_mask = ~({INPUT_WIDTH{1'b1}} << item_w);
  assign item_ext  = ACC_W'(bus.data & item_mask) << cnt_sh;

  // Bits above cnt are always zero, so placement is a plain OR and the
  // tail word comes out zero-padded for free.
  always_comb begin
    acc_nxt = acc_sh;
    cnt_nxt = cnt_sh;
    if (accept) begin
      acc_nxt = acc_sh | item_ext;
      cnt_nxt = cnt_sh + item_w;
    end
  end

  // Session state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_FILL;
    else       state <= state_nxt;
  end

  // Next state: enter flush on the last item, leave it (and pulse done)
  // once everything has been written; dropping wr_dma abandons the packet.
  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      S_FILL: begin
        if (accept && bus.last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          state_nxt = S_FILL;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = S_FILL;
    endcase
    if (!bus.wr_dma) begin
      state_nxt = S_FILL;
      done_set  = 1'b0;
    end
  end

  // Accumulator, address counter and registered DMA outputs. With wr_dma
  // low the buffer is cleared and the base address is reloaded each cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc       <= '0;
      cnt       <= '0;
      next_addr <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else if (!bus.wr_dma) begin
      acc       <= '0;
      cnt       <= '0;
      next_addr <= bus.dma_base_addr;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      wr_en_q <= emit;
      done_q  <= done_set;
      if (emit) begin
        wr_data_q <= acc[OUTPUT_WIDTH-1:0];
        wr_addr_q <= next_addr;
        next_addr <= next_addr + DMA_ADDR_WIDTH'(1);
      end
    end
  end

  assign bus.ready       = ready;
  assign bus.dma_wr_en   = wr_en_q;
  assign bus.dma_wr_addr = wr_addr_q;
  assign bus.dma_wr_data = wr_data_q;
  assign bus.done        = done_q;

`ifdef DRLP_WR_BUF_CNT_EN
  logic [15:0] wr_count_q;

  // Words written this session, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst || !bus.wr_dma)               wr_count_q <= '0;
    else if (emit && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
  end

  assign bus.wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_drlp_wr_buffer.sv
// tb_drlp_wr_buffer: directed and randomized sessions against a bit-queue
// reference model: accepted items are appended as bits, whole words are
// cut from the front, the last item pads to a word boundary.
module tb_drlp_wr_buffer;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  drlp_wr_buffer_if bus ();

  drlp_wr_buffer dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  bit          q_bits[$];
  logic [31:0] exp_words[$];
  logic [31:0] exp_addr = '0;
  bit          flushing = 1'b0;
  bit          prev_wr_en = 1'b0;
  bit          prev_dmardy = 1'b0;
  int          done_cnt = 0;
  int          sess_words = 0;
  logic [31:0] log_data[$];
  logic [31:0] log_addr[$];
  bit          rdy_log[$];
  logic [47:0] items_q[$];
  logic [1:0]  modes_q[$];
  bit          last_on_final = 1'b1;
  int          valid_pct = 100;
  int          rdy_pct = 100;
  int          bp_start = -1;
  int          bp_len = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_bits.delete();
    exp_words.delete();
    flushing = 1'b0;
  endtask

  task automatic model_push(input logic [47:0] d, input logic [1:0] m, input bit lst);
    int w;
    logic [31:0] wd;
    w = (m == 2'b01) ? 32 : (m == 2'b10) ? 40 : 48;
    for (int b = 0; b < w; b++) q_bits.push_back(d[b]);
    if (lst) begin
      while (q_bits.size() % 32 != 0) q_bits.push_back(1'b0);
      flushing = 1'b1;
    end
    while (q_bits.size() >= 32) begin
      for (int b = 0; b < 32; b++) wd[b] = q_bits.pop_front();
      exp_words.push_back(wd);
    end
  endtask

  // Check what the last edge produced.
  task automatic observe();
    logic [31:0] ew;
    if (bus.dma_wr_en) begin
      sess_words++;
      log_data.push_back(bus.dma_wr_data);
      log_addr.push_back(bus.dma_wr_addr);
      chk("wr_en_needs_dma_ready", 64'(prev_dmardy), 64'd1);
      chk("word_expected", 64'(exp_words.size() != 0), 64'd1);
      if (exp_words.size() != 0) begin
        ew = exp_words.pop_front();
        chk("wr_data", 64'(bus.dma_wr_data), 64'(ew));
        chk("wr_addr", 64'(bus.dma_wr_addr), 64'(exp_addr));
        exp_addr = exp_addr + 32'd1;
      end
    end
    if (bus.done) begin
      chk("done_expected", 64'(flushing), 64'd1);
      chk("done_no_pending", 64'(exp_words.size()), 64'd0);
      chk("done_after_word", 64'(prev_wr_en), 64'd1);
      flushing = 1'b0;
      done_cnt++;
    end
`ifdef DRLP_WR_BUF_CNT_EN
    chk("wr_count", 64'(bus.wr_count), 64'(sess_words));
`endif
    prev_wr_en = bus.dma_wr_en;
  endtask

  // One clock: inputs already driven after a negedge; settle, record the
  // handshake in the model, then check the outputs of the edge.
  task automatic cycle(input bit exp_rdy_low, output bit acc);
    acc = 1'b0;
    #1;
    if (exp_rdy_low) chk("bp_ready_low", 64'(bus.ready), 64'd0);
    if (i_rst) begin
      model_clear();
      exp_addr = '0;
      sess_words = 0;
    end else if (!bus.wr_dma) begin
      model_clear();
      exp_addr = bus.dma_base_addr;
      sess_words = 0;
    end else begin
      if (flushing) chk("ready_in_flush", 64'(bus.ready), 64'd0);
      if (bus.valid) rdy_log.push_back(bus.ready);
      if (bus.valid && bus.ready) begin
        acc = 1'b1;
        model_push(bus.data, bus.mode, bus.last);
      end
    end
    prev_dmardy = bus.dma_ready;
    @(negedge i_clk);
    observe();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, a);
  endtask

  task automatic start_session(input logic [31:0] base);
    bus.wr_dma = 1'b0;
    bus.valid = 1'b0;
    bus.last = 1'b0;
    bus.dma_base_addr = base;
    idle(2);
    log_data.delete();
    log_addr.delete();
    rdy_log.delete();
    bus.wr_dma = 1'b1;
  endtask

  task automatic add_item(input logic [47:0] d, input logic [1:0] m);
    items_q.push_back(d);
    modes_q.push_back(m);
  endtask

  // Stream the queued items, then wait for done when the packet is closed.
  task automatic run_items();
    int cyc;
    int d0;
    bit a;
    bit bp;
    cyc = 0;
    while (items_q.size() != 0 && cyc < 600) begin
      bus.valid = ($urandom_range(99) < valid_pct);
      bus.data = items_q[0];
      bus.mode = modes_q[0];
      bus.last = last_on_final && (items_q.size() == 1);
      bp = (bp_start >= 0) && (cyc >= bp_start) && (cyc < bp_start + bp_len);
      bus.dma_ready = bp ? 1'b0 : ($urandom_range(99) < rdy_pct);
      cycle(bp && (cyc == bp_start + bp_len - 1), a);
      if (a) begin
        void'(items_q.pop_front());
        void'(modes_q.pop_front());
      end
      cyc++;
    end
    bus.valid = 1'b0;
    bus.last = 1'b0;
    chk("items_accepted", 64'(items_q.size()), 64'd0);
    items_q.delete();
    modes_q.delete();
    bp_start = -1;
    if (last_on_final) begin
      d0 = done_cnt;
      cyc = 0;
      while (done_cnt == d0 && cyc < 300) begin
        bus.dma_ready = ($urandom_range(99) < rdy_pct);
        cycle(1'b0, a);
        cyc++;
      end
      chk("done_seen", 64'(done_cnt - d0), 64'd1);
      bus.dma_ready = 1'b1;
      idle(2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int ni;
    bus.wr_dma = 1'b0;
    bus.dma_base_addr = '0;
    bus.mode = 2'b00;
    bus.data = '0;
    bus.valid = 1'b0;
    bus.last = 1'b0;
    bus.dma_ready = 1'b1;
    @(negedge i_clk);
    idle(3);
    chk("rst_wr_en", 64'(bus.dma_wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.dma_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.dma_wr_data), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    i_rst = 1'b0;

    // Mode 01: one item per cycle, two words.
    start_session(32'h100);
    add_item(48'hFFFF_1111_1111, 2'b01);
    add_item(48'h0000_2222_2222, 2'b01);
    run_items();
    chk("m01_nwords", 64'(log_data.size()), 64'd2);
    chk("m01_w0", 64'(log_data[0]), 64'h1111_1111);
    chk("m01_a0", 64'(log_addr[0]), 64'h100);
    chk("m01_w1", 64'(log_data[1]), 64'h2222_2222);
    chk("m01_a1", 64'(log_addr[1]), 64'h101);
    chk("m01_rdy1", 64'(rdy_log[1]), 64'd1);

    // Mode 00: two 48-bit items -> three words, no tail.
    start_session(32'h2000);
    add_item(48'hA5A5_1122_3344, 2'b00);
    add_item(48'hC3C3_5566_7788, 2'b00);
    run_items();
    chk("m00_nwords", 64'(log_data.size()), 64'd3);
    chk("m00_w0", 64'(log_data[0]), 64'h1122_3344);
    chk("m00_w1", 64'(log_data[1]), 64'h7788_A5A5);
    chk("m00_w2", 64'(log_data[2]), 64'hC3C3_5566);
    chk("m00_a2", 64'(log_addr[2]), 64'h2002);

    // Mode 10: four items -> five words; then a lone item with a padded
    // tail in the same session, addresses continuing.
    start_session(32'h3000);
    add_item(48'hAB01_0000_0000, 2'b10);
    add_item(48'hAB02_0000_0001, 2'b10);
    add_item(48'hAB03_0000_0002, 2'b10);
    add_item(48'hAB04_0000_0003, 2'b10);
    run_items();
    chk("m10_nwords", 64'(log_data.size()), 64'd5);
    chk("m10_w1", 64'(log_data[1]), 64'h0000_0101);
    chk("m10_w2", 64'(log_data[2]), 64'h0002_0200);
    chk("m10_w3", 64'(log_data[3]), 64'h0303_0000);
    chk("m10_w4", 64'(log_data[4]), 64'h0400_0000);
    add_item(48'hFFEE_DEAD_BEEF, 2'b10);
    run_items();
    chk("tail_nwords", 64'(log_data.size()), 64'd7);
    chk("tail_w0", 64'(log_data[5]), 64'hDEAD_BEEF);
    chk("tail_w1", 64'(log_data[6]), 64'h0000_00EE);
    chk("tail_addr", 64'(log_addr[6]), 64'h3006);

    // Mode 00 continuous: ready 1,1,0 repeating.
    start_session(32'h4000);
    for (int i = 0; i < 12; i++) add_item({$urandom, $urandom}, 2'b00);
    run_items();
    for (int i = 0; i < 9; i++) chk("rdy_pattern", 64'(rdy_log[i]), 64'(i % 3 != 2));
    chk("pat_nwords", 64'(log_data.size()), 64'd18);

    // Backpressure: DMA stalls five cycles mid-stream.
    start_session(32'h5000);
    for (int i = 0; i < 10; i++) add_item({$urandom, $urandom}, 2'b00);
    bp_start = 4;
    bp_len = 5;
    run_items();
    chk("bp_nwords", 64'(log_data.size()), 64'd15);
    chk("bp_last_addr", 64'(log_addr[14]), 64'h500E);

    // Abort by wr_dma drop after one item: nothing written, no done.
    start_session(32'h6000);
    last_on_final = 1'b0;
    add_item(48'h1234_5678_9ABC, 2'b00);
    run_items();
    d0 = done_cnt;
    bus.wr_dma = 1'b0;
    idle(5);
    chk("abort_nwords", 64'(log_data.size()), 64'd0);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // Abort by reset after one item.
    start_session(32'h6100);
    add_item(48'h1234_5678_9ABC, 2'b00);
    run_items();
    i_rst = 1'b1;
    idle(3);
    i_rst = 1'b0;
    chk("rst_abort_nwords", 64'(log_data.size()), 64'd0);
    chk("rst_abort_no_done", 64'(done_cnt - d0), 64'd0);
    last_on_final = 1'b1;

    // New session after the aborts starts at its own base.
    start_session(32'h7000);
    add_item(48'h0000_CAFE_F00D, 2'b01);
    run_items();
    chk("restart_addr", 64'(log_addr[0]), 64'h7000);
    chk("restart_data", 64'(log_data[0]), 64'hCAFE_F00D);

    // Randomized sessions, random modes, valid gaps and DMA stalls; some
    // bases sit just below the address wrap.
    valid_pct = 75;
    rdy_pct = 60;
    for (int s = 0; s < 30; s++) begin
      start_session((s % 4 == 0) ? 32'hFFFF_FFFD : $urandom);
      for (int p = 0; p < 1 + int'($urandom_range(1)); p++) begin
        ni = 1 + int'($urandom_range(9));
        for (int i = 0; i < ni; i++) add_item(48'({$urandom, $urandom}), 2'($urandom_range(3)));
        run_items();
      end
    end

    bus.wr_dma = 1'b0;
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
